// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state enum and counter width helper.
// No ports; imported by rst_seq_sync.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    SYNC,
    HOLD,
    RELEASE,
    RUN
  } rst_seq_state_t;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Async-assert, sync-deassert shift chain whose D input is tied to 1.
// Ports: CLK clock, RST async active-high clear, q chain output.
module rst_sync_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic q
);

  logic [NUM_STAGES-1:0] chain;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      chain <= '0;
    end else begin
      chain <= {chain[NUM_STAGES-2:0], 1'b1};
    end
  end

  assign q = chain[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_sync.sv
// Reset synchroniser plus ordered release of NUM_RSTS active-low channels.
// Ports: CLK, RST (async high), SW_RST (sync soft reset), SYNC_RST[NUM_RSTS], RST_DONE.
module rst_seq_sync
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_RSTS    = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SW_RST,
  output logic [NUM_RSTS-1:0] SYNC_RST,
  output logic                RST_DONE
);

  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int GW = cnt_w(GAP_CYCLES);
  localparam int IW = cnt_w(NUM_RSTS);

  // From SYNC the sampling edge itself counts as the first hold cycle,
  // so the load is one short. A soft reset reloads the full count
  // because the first low sample of SW_RST is the anchor edge.
  localparam logic [HW-1:0] HOLD_LOAD =
    HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [HW-1:0] HOLD_FULL = HW'(HOLD_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_RSTS - 1);

  rst_seq_state_t      state, state_n;
  logic [HW-1:0]       hold_cnt, hold_n;
  logic [GW-1:0]       gap_cnt, gap_n;
  logic [IW-1:0]       idx, idx_n;
  logic [NUM_RSTS-1:0] sync_n;
  logic                done_n;
  logic                chain_out;
  logic                rel0;

  rst_sync_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_chain (
    .CLK(CLK),
    .RST(RST),
    .q  (chain_out)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= SYNC;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      idx      <= '0;
      SYNC_RST <= '0;
      RST_DONE <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      gap_cnt  <= gap_n;
      idx      <= idx_n;
      SYNC_RST <= sync_n;
      RST_DONE <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    gap_n   = gap_cnt;
    idx_n   = idx;
    sync_n  = SYNC_RST;
    done_n  = RST_DONE;
    rel0    = 1'b0;

    if (state != SYNC && SW_RST) begin
      state_n = HOLD;
      hold_n  = HOLD_FULL;
      gap_n   = '0;
      idx_n   = '0;
      sync_n  = '0;
      done_n  = 1'b0;
    end else begin
      unique case (state)
        SYNC: begin
          if (chain_out) begin
            if (HOLD_CYCLES == 0) begin
              rel0 = 1'b1;
            end else begin
              state_n = HOLD;
              hold_n  = HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            rel0 = 1'b1;
          end else begin
            hold_n = hold_cnt - HW'(1);
          end
        end
        RELEASE: begin
          if (gap_cnt == '0) begin
            for (int i = 0; i < NUM_RSTS; i++) begin
              if (IW'(i) == idx) begin
                sync_n[i] = 1'b1;
              end
            end
            if (idx == LAST_IDX) begin
              done_n  = 1'b1;
              state_n = RUN;
            end else begin
              idx_n = idx + IW'(1);
              gap_n = GAP_LOAD;
            end
          end else begin
            gap_n = gap_cnt - GW'(1);
          end
        end
        RUN: begin
        end
        default: begin
          state_n = SYNC;
        end
      endcase

      // Channel 0 release; with no gap (or a single channel) every
      // channel goes together and the sequence is complete.
      if (rel0) begin
        if (GAP_CYCLES == 0 || NUM_RSTS == 1) begin
          sync_n  = '1;
          done_n  = 1'b1;
          state_n = RUN;
        end else begin
          sync_n[0] = 1'b1;
          idx_n     = IW'(1);
          gap_n     = GAP_LOAD;
          state_n   = RELEASE;
        end
      end
    end
  end

endmodule
